// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ready handshake, and selects
// the next PC on commit. A fetch-timeout watchdog and a misaligned-target trap latch a sticky error.
//
// state | meaning
// IDLE  | first cycle after reset, no request issued
// FETCH | imem_req high, waiting for imem_ready (watchdog running)
// HOLD  | inst valid, waiting for commit to pick the next PC
// ERR   | sticky error, left only through reset
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  NPCOp,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [6:0]  Op,
    output logic [2:0]  Funct3,
    output logic [6:0]  Funct7,
    output logic        fetch_err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [7:0]  WAIT_LAST    = 8'(MAX_WAIT - 1);
    localparam logic [1:0]  ERR_NONE     = 2'b00;
    localparam logic [1:0]  ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0]  ERR_MISALIGN = 2'b10;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_inst;
    logic [31:0] w_inst_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic [1:0]  r_err_code;
    logic [1:0]  w_err_code_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    assign w_pc_plus4 = r_pc + 32'd4;

    // jalr clears bit 0 of the ALU result, as the ISA requires
    always_comb begin
        w_target = w_pc_plus4;
        case (NPCOp)
            2'b00:   w_target = w_pc_plus4;
            2'b01:   w_target = r_pc + imm;
            2'b10:   w_target = r_pc + imm;
            default: w_target = alu_result & 32'hFFFF_FFFE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_inst     <= NOP_INST;
            r_wait_cnt <= 8'd0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inst     <= w_inst_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_inst_nxt     = r_inst;
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_code_nxt = r_err_code;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    w_inst_nxt     = imem_rdata;
                    w_wait_cnt_nxt = 8'd0;
                    w_state_nxt    = S_HOLD;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = ERR_TIMEOUT;
                    end
                end
            end
            S_HOLD: begin
                if (commit) begin
                    if (w_target[1:0] == 2'b00) begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_state_nxt    = S_ERR;
                        w_err_code_nxt = ERR_MISALIGN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_ERR;
            end
        endcase
    end

    assign imem_req   = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign inst       = r_inst;
    assign inst_valid = (r_state == S_HOLD);
    assign Op         = r_inst[6:0];
    assign Funct3     = r_inst[14:12];
    assign Funct7     = r_inst[31:25];
    assign fetch_err  = (r_state == S_ERR);
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a per-cycle vector table for the main flow,
// plus hand sequences for wrap-around, watchdog limits and asynchronous reset.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rstn;
    logic [1:0]  NPCOp;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
    logic        inst_valid;
    logic [6:0]  Op;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        fetch_err;
    logic [1:0]  err_code;

    int n_vec  = 0;
    int n_fail = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(16)) dut (
        .clk(clk), .rstn(rstn), .NPCOp(NPCOp), .imm(imm), .alu_result(alu_result),
        .commit(commit), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4),
        .inst(inst), .inst_valid(inst_valid), .Op(Op), .Funct3(Funct3), .Funct7(Funct7),
        .fetch_err(fetch_err), .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic [31:0] rdata;
        logic        cmt;
        logic [1:0]  npc;
        logic [31:0] imm_v;
        logic [31:0] alu;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_iv;
        logic [31:0] e_inst;
        logic        e_err;
        logic [1:0]  e_code;
    } vec_t;

    function automatic vec_t vv(logic rdy, logic [31:0] rd, logic cm, logic [1:0] np,
                                logic [31:0] im, logic [31:0] al, logic rq, logic [31:0] p,
                                logic iv, logic [31:0] in, logic er, logic [1:0] cd);
        vec_t v;
        v.ready = rdy; v.rdata = rd; v.cmt = cm; v.npc = np; v.imm_v = im; v.alu = al;
        v.e_req = rq; v.e_pc = p; v.e_iv = iv; v.e_inst = in; v.e_err = er; v.e_code = cd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_outs(string tag, vec_t v);
        logic [31:0] e_p4;
        logic [31:0] e_in;
        e_p4 = v.e_pc + 32'd4;
        e_in = v.e_inst;
        chk({tag, " imem_req"},   {31'd0, imem_req},   {31'd0, v.e_req});
        chk({tag, " imem_addr"},  imem_addr,           v.e_pc);
        chk({tag, " pc"},         pc,                  v.e_pc);
        chk({tag, " pc_plus4"},   pc_plus4,            e_p4);
        chk({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, v.e_iv});
        chk({tag, " inst"},       inst,                e_in);
        chk({tag, " Op"},         {25'd0, Op},         {25'd0, e_in[6:0]});
        chk({tag, " Funct3"},     {29'd0, Funct3},     {29'd0, e_in[14:12]});
        chk({tag, " Funct7"},     {25'd0, Funct7},     {25'd0, e_in[31:25]});
        chk({tag, " fetch_err"},  {31'd0, fetch_err},  {31'd0, v.e_err});
        chk({tag, " err_code"},   {30'd0, err_code},   {30'd0, v.e_code});
    endtask

    // Inputs for a cycle are driven on the falling edge; outputs checked then reflect current state.
    task automatic cyc(string tag, vec_t v);
        @(negedge clk);
        imem_ready = v.ready; imem_rdata = v.rdata; commit = v.cmt;
        NPCOp = v.npc; imm = v.imm_v; alu_result = v.alu;
        #1;
        check_outs(tag, v);
    endtask

    // Leaves rstn released 1 time unit after a rising edge, so the next cyc sees IDLE.
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'h0; commit = 1'b0;
        NPCOp = 2'b00; imm = 32'h0; alu_result = 32'h0;
        #1;
        check_outs("reset", vv(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h13, 0, 2'b00));
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    localparam logic [31:0] I0 = 32'h0010_0093;
    localparam logic [31:0] A1 = 32'h0020_0113;
    localparam logic [31:0] A2 = 32'h0030_0193;
    localparam logic [31:0] A3 = 32'h4020_8233;
    localparam logic [31:0] B1 = 32'h0000_0463;
    localparam logic [31:0] B2 = 32'h0100_006F;
    localparam logic [31:0] B3 = 32'h0000_80E7;
    localparam logic [31:0] NOP = 32'h0000_0013;

    vec_t tbl[19];

    initial begin
        rstn = 1'b0;
        imem_ready = 1'b0; imem_rdata = 32'h0; commit = 1'b0;
        NPCOp = 2'b00; imm = 32'h0; alu_result = 32'h0;

        //          rdy rdata         cm npc  imm            alu    | req pc          iv inst er code
        tbl[0]  = vv(1, 32'h0,        0, 2'b00, 32'h0,        32'h0,   0, 32'h000, 0, NOP, 0, 2'b00);
        tbl[1]  = vv(1, I0,           0, 2'b00, 32'h0,        32'h0,   1, 32'h000, 0, NOP, 0, 2'b00);
        tbl[2]  = vv(0, 32'hDEADBEEF, 1, 2'b00, 32'h0,        32'h0,   0, 32'h000, 1, I0,  0, 2'b00);
        tbl[3]  = vv(1, A1,           0, 2'b00, 32'h0,        32'h0,   1, 32'h004, 0, I0,  0, 2'b00);
        tbl[4]  = vv(0, 32'h0,        1, 2'b00, 32'h0,        32'h0,   0, 32'h004, 1, A1,  0, 2'b00);
        tbl[5]  = vv(1, A2,           0, 2'b00, 32'h0,        32'h0,   1, 32'h008, 0, A1,  0, 2'b00);
        tbl[6]  = vv(0, 32'h0,        1, 2'b00, 32'h0,        32'h0,   0, 32'h008, 1, A2,  0, 2'b00);
        tbl[7]  = vv(1, A3,           0, 2'b00, 32'h0,        32'h0,   1, 32'h00C, 0, A2,  0, 2'b00);
        tbl[8]  = vv(1, 32'hDEADBEEF, 0, 2'b00, 32'h0,        32'h0,   0, 32'h00C, 1, A3,  0, 2'b00);
        tbl[9]  = vv(0, 32'h0,        1, 2'b10, 32'h0000_00F4, 32'h0,  0, 32'h00C, 1, A3,  0, 2'b00);
        tbl[10] = vv(0, 32'h0,        1, 2'b00, 32'h0,        32'h0,   1, 32'h100, 0, A3,  0, 2'b00);
        tbl[11] = vv(1, B1,           0, 2'b00, 32'h0,        32'h0,   1, 32'h100, 0, A3,  0, 2'b00);
        tbl[12] = vv(0, 32'h0,        1, 2'b01, 32'hFFFF_FFF0, 32'h0,  0, 32'h100, 1, B1,  0, 2'b00);
        tbl[13] = vv(1, B2,           0, 2'b00, 32'h0,        32'h0,   1, 32'h0F0, 0, B1,  0, 2'b00);
        tbl[14] = vv(0, 32'h0,        1, 2'b10, 32'h0000_0010, 32'h0,  0, 32'h0F0, 1, B2,  0, 2'b00);
        tbl[15] = vv(1, B3,           0, 2'b00, 32'h0,        32'h0,   1, 32'h100, 0, B2,  0, 2'b00);
        tbl[16] = vv(0, 32'h0,        1, 2'b11, 32'h0,        32'h203, 0, 32'h100, 1, B3,  0, 2'b00);
        tbl[17] = vv(1, 32'hCAFEF00D, 1, 2'b00, 32'h0,        32'h0,   0, 32'h100, 0, B3,  1, 2'b10);
        tbl[18] = vv(0, 32'h0,        0, 2'b00, 32'h0,        32'h0,   0, 32'h100, 0, B3,  1, 2'b10);

        do_reset();
        for (int i = 0; i < 19; i++) cyc($sformatf("tbl[%0d]", i), tbl[i]);

        // pc wraps from 0xFFFFFFFC to 0
        do_reset();
        cyc("wrap idle",  vv(1, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, NOP, 0, 2'b00));
        cyc("wrap f0",    vv(1, A1,    0, 2'b00, 32'h0, 32'h0, 1, 32'h0, 0, NOP, 0, 2'b00));
        cyc("wrap h0",    vv(0, 32'h0, 1, 2'b01, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 1, A1, 0, 2'b00));
        cyc("wrap f1",    vv(1, A2,    0, 2'b00, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 0, A1, 0, 2'b00));
        cyc("wrap h1",    vv(0, 32'h0, 1, 2'b00, 32'h0, 32'h0, 0, 32'hFFFF_FFFC, 1, A2, 0, 2'b00));
        chk("wrap pc_plus4 top", pc_plus4, 32'h0);
        cyc("wrap f2",    vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h0, 0, A2, 0, 2'b00));

        // watchdog: 16 FETCH cycles without ready -> ERR with timeout code
        do_reset();
        cyc("to idle", vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, NOP, 0, 2'b00));
        for (int i = 0; i < 16; i++)
            cyc($sformatf("to wait%0d", i), vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h0, 0, NOP, 0, 2'b00));
        cyc("to err",  vv(1, A1, 1, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, NOP, 1, 2'b01));
        cyc("to err2", vv(1, A1, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, NOP, 1, 2'b01));
        // async reset out of ERR
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async err fetch_err", {31'd0, fetch_err}, 32'd0);
        chk("async err err_code",  {30'd0, err_code},  32'd0);

        // ready on the 16th FETCH cycle captures normally
        do_reset();
        cyc("lim idle", vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, NOP, 0, 2'b00));
        for (int i = 0; i < 15; i++)
            cyc($sformatf("lim wait%0d", i), vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h0, 0, NOP, 0, 2'b00));
        cyc("lim last", vv(1, A3, 0, 2'b00, 32'h0, 32'h0, 1, 32'h0, 0, NOP, 0, 2'b00));
        cyc("lim hold", vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 1, A3, 0, 2'b00));
        // async reset out of HOLD
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async hold inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("async hold inst",       inst,                NOP);

        // async reset mid-FETCH while waiting, then normal restart
        do_reset();
        cyc("mid idle", vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, NOP, 0, 2'b00));
        cyc("mid f0",   vv(1, A1,    0, 2'b00, 32'h0, 32'h0, 1, 32'h0, 0, NOP, 0, 2'b00));
        cyc("mid h0",   vv(0, 32'h0, 1, 2'b10, 32'h40, 32'h0, 0, 32'h0, 1, A1, 0, 2'b00));
        cyc("mid w0",   vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h40, 0, A1, 0, 2'b00));
        cyc("mid w1",   vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h40, 0, A1, 0, 2'b00));
        #2 rstn = 1'b0;
        #1;
        chk("async fetch imem_req",  {31'd0, imem_req},   32'd0);
        chk("async fetch inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("async fetch fetch_err", {31'd0, fetch_err},  32'd0);
        chk("async fetch pc",        pc,                  32'h0);
        chk("async fetch inst",      inst,                NOP);
        do_reset();
        cyc("rst idle", vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 0, 32'h0, 0, NOP, 0, 2'b00));
        cyc("rst f0",   vv(0, 32'h0, 0, 2'b00, 32'h0, 32'h0, 1, 32'h0, 0, NOP, 0, 2'b00));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
